// File: rtl/sort_host.sv
`default_nettype none
// ============================================================================
// Module   : sort_host
// Brief    : Host initiator for the 8x4-bit sorter start/clear-valid handshake,
//            with an order + permutation self-check of the returned word.
// Revision : 1.0
// ============================================================================
module sort_host #(
  parameter int TIMEOUT = 255
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        in_valid_i,
  input  logic [3:0]  in_nibble_i,
  input  logic        go_i,
  input  logic        ack_i,
  output logic [31:0] nums_o,
  output logic        start_clear_o,
  input  logic        valid_i,
  input  logic [31:0] sorted_nums_i,
  output logic [31:0] result_o,
  output logic [3:0]  load_cnt_o,
  output logic        done_o,
  output logic        pass_o,
  output logic        timeout_o
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_WAIT  = 3'd1,
    S_CLEAR = 3'd2,
    S_CHECK = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  localparam logic [8:0] c_timeout = 9'(TIMEOUT);

  state_t      r_state;
  logic [31:0] r_nums;
  logic        r_start_clear;
  logic [31:0] r_result;
  logic [3:0]  r_load_cnt;
  logic        r_done;
  logic        r_pass;
  logic        r_timeout;
  logic [3:0]  r_hist [16];
  logic [7:0]  r_tmo_cnt;
  logic [2:0]  r_idx;
  logic        r_order;
  logic        r_mismatch;

  logic [2:0]  w_idx_prev;
  logic [3:0]  w_v;
  logic [3:0]  w_prev;
  logic        w_mismatch_nxt;
  logic        w_order_nxt;
  logic        w_tmo_hit;
  logic [7:0]  w_tmo_inc;

  assign w_idx_prev     = r_idx - 3'd1;
  assign w_v            = r_result[{r_idx, 2'b00} +: 4];
  assign w_prev         = r_result[{w_idx_prev, 2'b00} +: 4];
  // An empty histogram bin means the sorter returned a value we never sent.
  assign w_mismatch_nxt = r_mismatch | (r_hist[w_v] == 4'd0);
  assign w_order_nxt    = r_order & ~((r_idx != 3'd0) && (w_v < w_prev));
  assign w_tmo_hit      = ({1'b0, r_tmo_cnt} + 9'd1) >= c_timeout;
  assign w_tmo_inc      = (r_tmo_cnt == 8'hFF) ? r_tmo_cnt : r_tmo_cnt + 8'd1;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state       <= S_IDLE;
      r_nums        <= '0;
      r_start_clear <= 1'b0;
      r_result      <= '0;
      r_load_cnt    <= '0;
      r_done        <= 1'b0;
      r_pass        <= 1'b0;
      r_timeout     <= 1'b0;
      r_tmo_cnt     <= '0;
      r_idx         <= '0;
      r_order       <= 1'b0;
      r_mismatch    <= 1'b0;
      for (int k = 0; k < 16; k++) r_hist[k] <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          // A push wins over go, so go at count 7 with a push never starts.
          if (in_valid_i && (r_load_cnt < 4'd8)) begin
            r_nums[{r_load_cnt[2:0], 2'b00} +: 4] <= in_nibble_i;
            r_load_cnt                           <= r_load_cnt + 4'd1;
            r_hist[in_nibble_i]                  <= r_hist[in_nibble_i] + 4'd1;
          end else if (go_i && (r_load_cnt == 4'd8)) begin
            r_start_clear <= 1'b1;
            r_tmo_cnt     <= '0;
            r_state       <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (valid_i) begin
            r_result      <= sorted_nums_i;
            r_start_clear <= 1'b0;
            r_tmo_cnt     <= w_tmo_inc;
            r_state       <= S_CLEAR;
          end else if (w_tmo_hit) begin
            r_start_clear <= 1'b0;
            r_timeout     <= 1'b1;
            r_pass        <= 1'b0;
            r_done        <= 1'b1;
            r_state       <= S_DONE;
          end else begin
            r_tmo_cnt <= w_tmo_inc;
          end
        end
        S_CLEAR: begin
          if (!valid_i) begin
            r_idx      <= '0;
            r_order    <= 1'b1;
            r_mismatch <= 1'b0;
            r_state    <= S_CHECK;
          end else if (w_tmo_hit) begin
            r_timeout <= 1'b1;
            r_pass    <= 1'b0;
            r_done    <= 1'b1;
            r_state   <= S_DONE;
          end else begin
            r_tmo_cnt <= w_tmo_inc;
          end
        end
        S_CHECK: begin
          if (r_hist[w_v] != 4'd0) r_hist[w_v] <= r_hist[w_v] - 4'd1;
          r_mismatch <= w_mismatch_nxt;
          r_order    <= w_order_nxt;
          r_idx      <= r_idx + 3'd1;
          if (r_idx == 3'd7) begin
            r_pass  <= w_order_nxt & ~w_mismatch_nxt;
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end
        end
        S_DONE: begin
          if (ack_i) begin
            r_load_cnt <= '0;
            r_nums     <= '0;
            r_done     <= 1'b0;
            r_pass     <= 1'b0;
            r_timeout  <= 1'b0;
            for (int k = 0; k < 16; k++) r_hist[k] <= '0;
            r_state    <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign nums_o        = r_nums;
  assign start_clear_o = r_start_clear;
  assign result_o      = r_result;
  assign load_cnt_o    = r_load_cnt;
  assign done_o        = r_done;
  assign pass_o        = r_pass;
  assign timeout_o     = r_timeout;

endmodule
`default_nettype wire

// File: tb/tb_sort_host.sv
`default_nettype none
// ============================================================================
// Module   : tb_sort_host
// Brief    : Randomized scoreboard bench for sort_host with a behavioural sorter.
// Revision : 1.0
// ============================================================================
module tb_sort_host;

  localparam int TMO = 20;

  logic        clk;
  logic        rst_i;
  logic        in_valid_i;
  logic [3:0]  in_nibble_i;
  logic        go_i;
  logic        ack_i;
  logic [31:0] nums_o;
  logic        start_clear_o;
  logic        valid_i;
  logic [31:0] sorted_nums_i;
  logic [31:0] result_o;
  logic [3:0]  load_cnt_o;
  logic        done_o;
  logic        pass_o;
  logic        timeout_o;

  sort_host #(.TIMEOUT(TMO)) dut (
    .clk_i        (clk),
    .rst_i        (rst_i),
    .in_valid_i   (in_valid_i),
    .in_nibble_i  (in_nibble_i),
    .go_i         (go_i),
    .ack_i        (ack_i),
    .nums_o       (nums_o),
    .start_clear_o(start_clear_o),
    .valid_i      (valid_i),
    .sorted_nums_i(sorted_nums_i),
    .result_o     (result_o),
    .load_cnt_o   (load_cnt_o),
    .done_o       (done_o),
    .pass_o       (pass_o),
    .timeout_o    (timeout_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] res;
    logic        chk_res;
    logic        pass;
    logic        tmo;
  } exp_t;

  exp_t        sb_q[$];
  exp_t        mon_e;
  int          total = 0;
  int          bad   = 0;

  // Reference state: what has been loaded, in push order.
  logic [3:0]  m_nib [8];
  int          m_cnt = 0;

  // Sorter model controls.
  int          sm_mode = 0;
  logic [31:0] sm_word = '0;
  int          sm_lat  = 1;
  int          sm_hold = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] m_pack();
    logic [31:0] w = '0;
    for (int i = 0; i < m_cnt; i++) w[4*i +: 4] = m_nib[i];
    return w;
  endfunction

  function automatic logic [31:0] m_sorted();
    int          cnt [16];
    int          k = 0;
    logic [31:0] w = '0;
    for (int v = 0; v < 16; v++) cnt[v] = 0;
    for (int i = 0; i < 8; i++) cnt[m_nib[i]]++;
    for (int v = 0; v < 16; v++)
      for (int c = 0; c < cnt[v]; c++) begin
        w[4*k +: 4] = 4'(v);
        k++;
      end
    return w;
  endfunction

  function automatic logic [31:0] corrupt(input logic [31:0] s, input int kind);
    logic [31:0] w = s;
    int          i = $urandom_range(0, 7);
    int          j = $urandom_range(0, 7);
    logic [3:0]  t;
    if (kind == 1) w[4*i +: 4] = 4'($urandom_range(0, 15));
    else if (kind == 2) begin
      t = w[4*i +: 4];
      w[4*i +: 4] = w[4*j +: 4];
      w[4*j +: 4] = t;
    end
    return w;
  endfunction

  // Behavioural sorter: answers start with the programmed word, drops valid on clear.
  initial begin : sorter_model
    valid_i       = 1'b0;
    sorted_nums_i = '0;
    forever begin
      @(negedge clk);
      if (start_clear_o && !valid_i && sm_mode == 0) begin
        repeat (sm_lat) @(negedge clk);
        valid_i       = 1'b1;
        sorted_nums_i = sm_word;
        for (int i = 0; i < 100 && start_clear_o; i++) @(negedge clk);
        repeat (sm_hold) @(negedge clk);
        valid_i = 1'b0;
      end
    end
  end

  // Monitor: every rising done_o consumes one scoreboard entry.
  logic prev_done = 1'b0;
  always @(negedge clk) begin
    if (done_o && !prev_done) begin
      if (sb_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_done: got done=1 expected no result");
      end else begin
        mon_e = sb_q.pop_front();
        check("done_pass", 32'(pass_o), 32'(mon_e.pass));
        check("done_timeout", 32'(timeout_o), 32'(mon_e.tmo));
        if (mon_e.chk_res) check("done_result", result_o, mon_e.res);
      end
    end
    prev_done = done_o;
  end

  task automatic push(input logic [3:0] nib, input logic with_go);
    in_valid_i  = 1'b1;
    in_nibble_i = nib;
    go_i        = with_go;
    @(negedge clk);
    in_valid_i = 1'b0;
    go_i       = 1'b0;
    if (m_cnt < 8) begin
      m_nib[m_cnt] = nib;
      m_cnt++;
    end
  endtask

  task automatic wait_done(input string name);
    for (int n = 0; n < 200 && !done_o; n++) @(negedge clk);
    if (!done_o) begin
      total++;
      bad++;
      $display("FAIL %s_no_done: got done=0 expected done=1", name);
    end
  endtask

  task automatic do_ack();
    ack_i = 1'b1;
    @(negedge clk);
    ack_i = 1'b0;
    m_cnt = 0;
    check("ack_load_cnt", 32'(load_cnt_o), 32'd0);
    check("ack_done", 32'(done_o), 32'd0);
    check("ack_nums", nums_o, 32'd0);
  endtask

  task automatic run(input logic [31:0] resp, input int lat, input int hold);
    exp_t e;
    sm_mode = 0;
    sm_word = resp;
    sm_lat  = lat;
    sm_hold = hold;
    e.res     = resp;
    e.chk_res = 1'b1;
    e.pass    = (resp == m_sorted());
    e.tmo     = 1'b0;
    sb_q.push_back(e);
    go_i = 1'b1;
    @(negedge clk);
    go_i = 1'b0;
    check("start_rise", 32'(start_clear_o), 32'd1);
    check("nums_in_wait", nums_o, m_pack());
    wait_done("run");
  endtask

  logic [31:0] resp;
  logic [31:0] saved_nums;
  int          n;

  initial begin
    rst_i       = 1'b1;
    in_valid_i  = 1'b0;
    in_nibble_i = '0;
    go_i        = 1'b0;
    ack_i       = 1'b0;
    repeat (3) @(negedge clk);
    rst_i = 1'b0;
    check("reset_outputs", {nums_o, result_o}, 64'd0 >> 0);
    check("reset_ctrl", {25'd0, start_clear_o, load_cnt_o, done_o, pass_o}, 32'd0);
    check("reset_timeout", 32'(timeout_o), 32'd0);

    // Nominal sort
    foreach (m_nib[i]) m_nib[i] = '0;
    push(4'h7, 0); push(4'h3, 0); push(4'hF, 0); push(4'h0, 0);
    push(4'h3, 0); push(4'h9, 0); push(4'h1, 0); push(4'h3, 0);
    check("nominal_load_cnt", 32'(load_cnt_o), 32'd8);
    check("nominal_nums", nums_o, 32'h31930F37);
    run(32'hF9733310, 3, 1);
    check("nominal_result", result_o, 32'hF9733310);
    check("nominal_pass", 32'(pass_o), 32'd1);
    do_ack();

    // Wrong permutation and unordered responses for the same input
    push(4'h7, 0); push(4'h3, 0); push(4'hF, 0); push(4'h0, 0);
    push(4'h3, 0); push(4'h9, 0); push(4'h1, 0); push(4'h3, 0);
    run(32'hF9773310, 2, 0);
    check("perm_pass", 32'(pass_o), 32'd0);
    do_ack();
    push(4'h7, 0); push(4'h3, 0); push(4'hF, 0); push(4'h0, 0);
    push(4'h3, 0); push(4'h9, 0); push(4'h1, 0); push(4'h3, 0);
    run(32'hF9733301, 4, 2);
    check("order_pass", 32'(pass_o), 32'd0);
    do_ack();

    // Load boundaries
    for (int i = 0; i < 7; i++) push(4'($urandom_range(0, 15)), 0);
    go_i = 1'b1;
    @(negedge clk);
    go_i = 1'b0;
    @(negedge clk);
    check("go_at7_start", 32'(start_clear_o), 32'd0);
    check("go_at7_cnt", 32'(load_cnt_o), 32'd7);
    push(4'($urandom_range(0, 15)), 1);
    check("pushgo_cnt", 32'(load_cnt_o), 32'd8);
    @(negedge clk);
    check("pushgo_start", 32'(start_clear_o), 32'd0);
    saved_nums = nums_o;
    push(4'($urandom_range(0, 15)), 0);
    check("ninth_cnt", 32'(load_cnt_o), 32'd8);
    check("ninth_nums", nums_o, saved_nums);
    check("ninth_model", nums_o, m_pack());
    run(m_sorted(), 1, 0);
    do_ack();

    // Randomized runs with correct and corrupted responses
    for (int r = 0; r < 24; r++) begin
      for (int i = 0; i < 8; i++) push(4'($urandom_range(0, 15)), 0);
      if ($urandom_range(0, 3) == 0) push(4'($urandom_range(0, 15)), 0);
      resp = corrupt(m_sorted(), int'($urandom_range(0, 2)));
      run(resp, int'($urandom_range(1, 6)), int'($urandom_range(0, 3)));
      do_ack();
    end

    // Timeout: sorter never answers
    for (int i = 0; i < 8; i++) push(4'($urandom_range(0, 15)), 0);
    sm_mode = 1;
    begin
      exp_t e;
      e.res = '0; e.chk_res = 1'b0; e.pass = 1'b0; e.tmo = 1'b1;
      sb_q.push_back(e);
    end
    go_i = 1'b1;
    @(negedge clk);
    go_i = 1'b0;
    check("tmo_start_rise", 32'(start_clear_o), 32'd1);
    n = 0;
    while (!done_o && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("tmo_cycles", 32'(n), 32'(TMO));
    check("tmo_start_low", 32'(start_clear_o), 32'd0);
    check("tmo_flag", 32'(timeout_o), 32'd1);
    check("tmo_pass", 32'(pass_o), 32'd0);
    do_ack();

    // Reset while waiting on the sorter
    for (int i = 0; i < 8; i++) push(4'($urandom_range(0, 15)), 0);
    go_i = 1'b1;
    @(negedge clk);
    go_i = 1'b0;
    repeat (3) @(negedge clk);
    rst_i = 1'b1;
    @(negedge clk);
    rst_i = 1'b0;
    m_cnt = 0;
    check("rst_wait_data", {nums_o, result_o}, 64'd0 >> 0);
    check("rst_wait_ctrl", {25'd0, start_clear_o, load_cnt_o, done_o, pass_o}, 32'd0);
    check("rst_wait_tmo", 32'(timeout_o), 32'd0);
    sm_mode = 0;

    // Re-run with all-equal operands
    for (int i = 0; i < 8; i++) push(4'hA, 0);
    run(32'hAAAAAAAA, 2, 1);
    check("rerun_result", result_o, 32'hAAAAAAAA);
    check("rerun_pass", 32'(pass_o), 32'd1);
    do_ack();

    repeat (3) @(negedge clk);
    if (sb_q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL scoreboard_left: got %0d pending expected 0", sb_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
